// File: rtl/win_pkg.sv
// rtl/win_pkg.sv - shared window layout constants and the per-index bit offset
package win_pkg;
   localparam int DSIZE_DEFAULT = 8;
   localparam int WIN_W         = 9 * DSIZE_DEFAULT;

   // Pixel 0 (oldest column, top row) sits in the most significant slot.
   function automatic int win_lsb(input int idx, input int dsize);
      return (8 - idx) * dsize;
   endfunction
endpackage

// File: rtl/window_gen_3x3_if.sv
// rtl/window_gen_3x3_if.sv - raster pixel input and 3x3 window output bundle
interface window_gen_3x3_if #(
   parameter int DSIZE = 8,
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
);
   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);

   logic                 i_sof;
   logic                 i_valid;
   logic [DSIZE-1:0]     i_pixel;
   logic                 o_valid;
   logic [9*DSIZE-1:0]   o_window;
   logic [XW-1:0]        o_x;
   logic [YW-1:0]        o_y;
   logic                 o_last;

   modport master (
      output i_sof, i_valid, i_pixel,
      input  o_valid, o_window, o_x, o_y, o_last
   );

   modport slave (
      input  i_sof, i_valid, i_pixel,
      output o_valid, o_window, o_x, o_y, o_last
   );
endinterface

// File: rtl/line_delay.sv
// rtl/line_delay.sv - one image line of delay, read-before-write at the column address
module line_delay #(
   parameter int DSIZE = 8,
   parameter int DEPTH = 640
) (
   input  logic                     clk,
   input  logic                     en,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [DSIZE-1:0]         din,
   output logic [DSIZE-1:0]         dout
);
   logic [DSIZE-1:0] mem [DEPTH];

   // Combinational read returns the value written one line ago at this column.
   assign dout = mem[addr];

   always_ff @(posedge clk) begin
      if (en) begin
         mem[addr] <= din;
      end
   end
endmodule

// File: rtl/window_gen_3x3.sv
// rtl/window_gen_3x3.sv - raster to 3x3 neighbourhood generator for the Gaussian filter
module window_gen_3x3 #(
   parameter int DSIZE = 8,
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input logic              i_clk,
   input logic              i_rst_n,
   window_gen_3x3_if.slave  bus
);
   import win_pkg::*;

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);

   logic [XW-1:0]        col_q, cur_col, nxt_col;
   logic [YW-1:0]        row_q, cur_row, nxt_row;
   logic [DSIZE-1:0]     tap1, tap2;
   logic [DSIZE-1:0]     win_q [9];
   logic [DSIZE-1:0]     win_d [9];
   logic [9*DSIZE-1:0]   pack_d;
   logic                 emit, at_end;

   logic                 valid_q, last_q;
   logic [9*DSIZE-1:0]   window_q;
   logic [XW-1:0]        x_q;
   logic [YW-1:0]        y_q;

   // Start of frame overrides the counters for the current cycle so a
   // coincident valid pixel lands at (0,0).
   always_comb begin
      cur_col = bus.i_sof ? '0 : col_q;
      cur_row = bus.i_sof ? '0 : row_q;
      nxt_col = cur_col;
      nxt_row = cur_row;
      if (bus.i_valid) begin
         if (cur_col == XW'(IMG_W - 1)) begin
            nxt_col = '0;
            nxt_row = (cur_row == YW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
         end else begin
            nxt_col = cur_col + 1'b1;
         end
      end
   end

   assign emit   = bus.i_valid && (cur_row >= YW'(2)) && (cur_col >= XW'(2));
   assign at_end = (cur_row == YW'(IMG_H - 1)) && (cur_col == XW'(IMG_W - 1));

   line_delay #(.DSIZE(DSIZE), .DEPTH(IMG_W)) u_line1 (
      .clk  (i_clk),
      .en   (bus.i_valid),
      .addr (cur_col),
      .din  (bus.i_pixel),
      .dout (tap1)
   );

   line_delay #(.DSIZE(DSIZE), .DEPTH(IMG_W)) u_line2 (
      .clk  (i_clk),
      .en   (bus.i_valid),
      .addr (cur_col),
      .din  (tap1),
      .dout (tap2)
   );

   // Index = col*3 + row; the new column enters at indices 6..8.
   always_comb begin
      for (int i = 0; i < 6; i++) begin
         win_d[i] = win_q[i + 3];
      end
      win_d[6] = tap2;
      win_d[7] = tap1;
      win_d[8] = bus.i_pixel;
   end

   always_comb begin
      pack_d = '0;
      for (int i = 0; i < 9; i++) begin
         pack_d[win_lsb(i, DSIZE) +: DSIZE] = win_d[i];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         col_q    <= '0;
         row_q    <= '0;
         for (int i = 0; i < 9; i++) begin
            win_q[i] <= '0;
         end
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         window_q <= '0;
         x_q      <= '0;
         y_q      <= '0;
      end else begin
         col_q   <= nxt_col;
         row_q   <= nxt_row;
         valid_q <= emit;
         last_q  <= emit && at_end;
         if (bus.i_valid) begin
            for (int i = 0; i < 9; i++) begin
               win_q[i] <= win_d[i];
            end
         end
         if (emit) begin
            window_q <= pack_d;
            x_q      <= cur_col - 1'b1;
            y_q      <= cur_row - 1'b1;
         end
      end
   end

   assign bus.o_valid  = valid_q;
   assign bus.o_last   = last_q;
   assign bus.o_window = window_q;
   assign bus.o_x      = x_q;
   assign bus.o_y      = y_q;
endmodule

// File: tb/tb_window_gen_3x3.sv
// tb/tb_window_gen_3x3.sv - directed vector bench for window_gen_3x3 on a 5x4 image
module tb_window_gen_3x3;
   localparam int W = 5;
   localparam int H = 4;
   localparam int D = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   window_gen_3x3_if #(.DSIZE(D), .IMG_W(W), .IMG_H(H)) bus ();

   window_gen_3x3 #(.DSIZE(D), .IMG_W(W), .IMG_H(H)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave)
   );

   typedef struct {
      logic sof;
      logic vld;
      int   r;
      int   c;
      logic ev;
      int   ey;
      int   ex;
      logic el;
   } vec_t;

   vec_t          tbl [21];
   int            n_checks = 0;
   int            n_fail   = 0;
   int            n_win;
   logic [71:0]   first_win, last_win;
   logic [71:0]   held_win;
   int            held_x, held_y;

   function automatic logic [7:0] pix(input int r, input int c);
      return 8'(r * 16 + c);
   endfunction

   // Builds the window by appending pixels in index order, index 0 ends up in the MSBs.
   function automatic logic [71:0] win_of(input int y, input int x);
      logic [71:0] w;
      w = '0;
      for (int col = 0; col < 3; col++) begin
         for (int row = 0; row < 3; row++) begin
            w = {w[63:0], pix(y - 1 + row, x - 1 + col)};
         end
      end
      return w;
   endfunction

   task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic sof, input logic vld, input int r, input int c,
                       input logic ev, input int ey, input int ex, input logic el);
      @(negedge clk);
      bus.i_sof   = sof;
      bus.i_valid = vld;
      bus.i_pixel = vld ? pix(r, c) : 8'h00;
      @(posedge clk);
      #1;
      chk("o_valid", 72'(bus.o_valid), 72'(ev));
      chk("o_last", 72'(bus.o_last), 72'(ev && el));
      if (ev) begin
         held_win = win_of(ey, ex);
         held_x   = ex;
         held_y   = ey;
      end
      chk("o_window", bus.o_window, held_win);
      chk("o_x", 72'(bus.o_x), 72'(held_x));
      chk("o_y", 72'(bus.o_y), 72'(held_y));
      if (bus.o_valid) begin
         if (n_win == 0) first_win = bus.o_window;
         last_win = bus.o_window;
         n_win++;
      end
   endtask

   task automatic feed(input logic first_sof, input int gap_pct, input int n_px);
      int r, c;
      for (int k = 0; k < n_px; k++) begin
         r = k / W;
         c = k % W;
         if (gap_pct > 0) begin
            while (int'($urandom_range(99)) < gap_pct) begin
               step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
            end
         end
         step(first_sof && (k == 0), 1'b1, r, c, (r >= 2) && (c >= 2), r - 1, c - 1,
              (r == H - 1) && (c == W - 1));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, " o_valid"}, 72'(bus.o_valid), 72'd0);
      chk({tag, " o_last"}, 72'(bus.o_last), 72'd0);
      chk({tag, " o_window"}, bus.o_window, 72'd0);
      chk({tag, " o_x"}, 72'(bus.o_x), 72'd0);
      chk({tag, " o_y"}, 72'(bus.o_y), 72'd0);
   endtask

   initial begin
      bus.i_sof   = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_pixel = '0;
      held_win    = '0;
      held_x      = 0;
      held_y      = 0;
      n_win       = 0;

      tbl[0] = '{sof: 1'b1, vld: 1'b0, r: 0, c: 0, ev: 1'b0, ey: 0, ex: 0, el: 1'b0};
      for (int k = 0; k < W * H; k++) begin
         tbl[k + 1] = '{sof: 1'b0, vld: 1'b1, r: k / W, c: k % W,
                        ev: (k / W >= 2) && (k % W >= 2), ey: k / W - 1, ex: k % W - 1,
                        el: (k == W * H - 1)};
      end

      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Continuous frame, i_sof on an idle cycle ahead of pixel (0,0).
      n_win = 0;
      for (int k = 0; k < 21; k++) begin
         step(tbl[k].sof, tbl[k].vld, tbl[k].r, tbl[k].c,
              tbl[k].ev, tbl[k].ey, tbl[k].ex, tbl[k].el);
      end
      chk("frame1 count", 72'(n_win), 72'd6);
      chk("frame1 first", first_win, 72'h00_10_20_01_11_21_02_12_22);
      chk("frame1 last", last_win, 72'h12_22_32_13_23_33_14_24_34);

      // Idle cycle holds outputs.
      step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0);

      // Second frame without i_sof.
      n_win = 0;
      feed(1'b0, 0, W * H);
      chk("frame2 count", 72'(n_win), 72'd6);

      // Frame with random idle gaps, i_sof together with the first pixel.
      n_win = 0;
      feed(1'b1, 50, W * H);
      chk("gap count", 72'(n_win), 72'd6);
      chk("gap last", last_win, 72'h12_22_32_13_23_33_14_24_34);

      // Abandon a frame at pixel (2,3) with a new i_sof on that pixel.
      n_win = 0;
      feed(1'b1, 0, 2 * W + 3);
      chk("partial count", 72'(n_win), 72'd1);
      n_win = 0;
      feed(1'b1, 0, W * H);
      chk("restart count", 72'(n_win), 72'd6);
      chk("restart first", first_win, 72'h00_10_20_01_11_21_02_12_22);

      // Reset in the middle of row 3.
      feed(1'b1, 0, 3 * W + 2);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      held_win = '0;
      held_x   = 0;
      held_y   = 0;
      bus.i_valid = 1'b0;
      bus.i_sof   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n_win = 0;
      feed(1'b0, 0, W * H);
      chk("post-reset count", 72'(n_win), 72'd6);
      chk("post-reset first", first_win, 72'h00_10_20_01_11_21_02_12_22);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
